// File: rtl/rotate_left_seq.sv
// Multi-cycle rotate-left unit: captures A/B on start, applies one power-of-two
// rotation step per cycle (log-step), and returns R with a one-cycle done pulse.
module rotate_left_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
);

  localparam int unsigned CW = (LOG2W > 1) ? $clog2(LOG2W) : 1;

  typedef enum logic {IDLE, ROT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [LOG2W-1:0]   amt_q, amt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot_step;
  logic [WIDTH-1:0]   step_val;

  // Rotate by 2^cnt: upper half of the doubled word shifted left.
  always_comb begin
    dbl      = {acc_q, acc_q} << (WIDTH'(1) << cnt_q);
    rot_step = dbl[2*WIDTH-1:WIDTH];
    step_val = amt_q[cnt_q] ? rot_step : acc_q;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = A;
          amt_d   = B[LOG2W-1:0];
          cnt_d   = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        acc_d = step_val;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LOG2W - 1)) begin
          r_d     = step_val;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ROT);
  assign done = done_q;
  assign R    = r_q;

endmodule

// File: tb/tb_rotate_left_seq.sv
// Directed and randomized checks of rotate_left_seq against hand-computed
// values and a shift/or reference model.
module tb_rotate_left_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] R;

  int unsigned n_checks;
  int unsigned n_err;
  logic [31:0] last_r;

  rotate_left_seq #(.WIDTH(32), .LOG2W(5)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol_ref(input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    return (a << sh) | (a >> ((32 - sh) % 32));
  endfunction

  // One accepted op: checks busy window, R hold, latency, result, done drop.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int n;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom;
    n = 0;
    while (!done && n < 20) begin
      check("busy_during", {31'd0, busy}, 32'd1);
      check("r_hold", R, last_r);
      @(negedge clk);
      n++;
    end
    check("latency", n, 32'd5);
    check("result", R, exp);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    last_r = exp;
    @(negedge clk);
    check("done_drop", {31'd0, done}, 32'd0);
    check("r_after", R, exp);
  endtask

  initial begin
    int ndone;
    int first_done;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks = 0;
    n_err    = 0;
    last_r   = '0;
    start    = 1'b0;
    A        = '0;
    B        = '0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r", R, 32'd0);
    clr = 1'b1;

    do_op(32'h80000001, 32'd1, 32'h00000003);
    do_op(32'h12345678, 32'hFFFFFFE4, 32'h23456781);
    do_op(32'h00000001, 32'd31, 32'h80000000);
    do_op(32'hDEADBEEF, 32'd32, 32'hDEADBEEF);
    do_op(32'hDEADBEEF, 32'd64, 32'hDEADBEEF);
    do_op(32'h0000FFFF, 32'd16, 32'hFFFF0000);

    // start held high: accepts at edges 1, 7, 13; completes at 6, 12, 18.
    @(negedge clk);
    A = 32'h0000000F; B = 32'd8; start = 1'b1;
    ndone = 0;
    first_done = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("cont_r", R, 32'h00000F00);
        check("cont_pos", k, 32'(6 * ndone));
        A = 32'h0000000F; B = 32'd8;
      end else begin
        A = $urandom; B = $urandom;
      end
    end
    start = 1'b0;
    check("cont_count", ndone, 32'd3);
    last_r = 32'h00000F00;
    repeat (8) @(negedge clk);
    check("cont_idle", {31'd0, busy}, 32'd0);

    // second start while busy is ignored
    @(negedge clk);
    A = 32'h00000001; B = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 32'hFFFF0000; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    first_done = 0;
    for (int k = 3; k <= 14; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        first_done = k;
        check("ign_r", R, 32'h00000002);
      end
    end
    check("ign_count", ndone, 32'd1);
    check("ign_pos", first_done, 32'd5);
    last_r = 32'h00000002;

    // reset in the middle of an op
    @(negedge clk);
    A = 32'h0F0F0F0F; B = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    clr = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_r", R, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_no_done", ndone, 32'd0);
    check("rst_r_held", R, 32'd0);
    last_r = '0;
    do_op(32'hA5A5A5A5, 32'd16, 32'hA5A5A5A5);
    do_op(32'hA5A5A5A5, 32'd1, 32'h4B4B4B4B);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op(ra, rb, rol_ref(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
